// File: rtl/queue.sv
// rtl/queue.sv - show-ahead synchronous FIFO with valid/ready handshake on both sides
// Note: rst_n is active-high despite its name; init is a synchronous flush.
module queue #(
  parameter type ET   = logic [31:0],
  parameter int  SIZE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init,
  output logic [$clog2(SIZE+1)-1:0] count,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  ET                         in,
  output logic                      out_val,
  input  logic                      out_rdy,
  output ET                         out
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;

  ET             mem [SIZE];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake flags depend on registered state only, so a full queue never
  // accepts even when a pop happens in the same cycle.
  assign in_rdy  = (count < CW'(SIZE));
  assign out_val = (count != '0);
  assign out     = mem[rd_ptr];
  assign push    = in_val & in_rdy;
  assign pop     = out_val & out_rdy;

  always_ff @(posedge clk) begin
    if (rst_n || init) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= adv(wr_ptr);
      if (pop)  rd_ptr <= adv(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst_n && !init) mem[wr_ptr] <= in;
  end

endmodule

// File: tb/tb_queue.sv
// tb/tb_queue.sv - directed plus random checks of queue (SIZE=3 and SIZE=2) against queue models
module tb_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic        in_val = 1'b0;
  logic [31:0] din = '0;
  logic        out_rdy = 1'b0;

  logic [1:0]  count3, count2;
  logic        in_rdy3, in_rdy2, out_val3, out_val2;
  logic [31:0] out3, out2;

  logic [31:0] q3[$];
  logic [31:0] q2[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  queue #(.ET(logic [31:0]), .SIZE(3)) u3 (
    .clk(clk), .rst_n(rst), .init(init), .count(count3),
    .in_val(in_val), .in_rdy(in_rdy3), .in(din),
    .out_val(out_val3), .out_rdy(out_rdy), .out(out3)
  );

  queue #(.ET(logic [31:0]), .SIZE(2)) u2 (
    .clk(clk), .rst_n(rst), .init(init), .count(count2),
    .in_val(in_val), .in_rdy(in_rdy2), .in(din),
    .out_val(out_val2), .out_rdy(out_rdy), .out(out2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the models by the FIFO rules, compare all outputs.
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] d, input bit o);
    bit p3, po3, p2, po2;
    rst = r; init = f; in_val = v; din = d; out_rdy = o;
    p3  = v && (q3.size() < 3);
    po3 = o && (q3.size() > 0);
    p2  = v && (q2.size() < 2);
    po2 = o && (q2.size() > 0);
    @(posedge clk);
    if (r || f) begin
      q3.delete();
      q2.delete();
    end else begin
      if (po3) void'(q3.pop_front());
      if (p3)  q3.push_back(d);
      if (po2) void'(q2.pop_front());
      if (p2)  q2.push_back(d);
    end
    #1;
    check("count3", 32'(count3), 32'(q3.size()));
    check("out_val3", 32'(out_val3), 32'(q3.size() != 0));
    check("in_rdy3", 32'(in_rdy3), 32'(q3.size() < 3));
    if (q3.size() > 0) check("out3", out3, q3[0]);
    check("count2", 32'(count2), 32'(q2.size()));
    check("out_val2", 32'(out_val2), 32'(q2.size() != 0));
    check("in_rdy2", 32'(in_rdy2), 32'(q2.size() < 2));
    if (q2.size() > 0) check("out2", out2, q2[0]);
  endtask

  initial begin
    // reset then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_count3", 32'(count3), 0);
    check("rst_in_rdy3", 32'(in_rdy3), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("idle_out_val3", 32'(out_val3), 0);

    // fill and drain
    step(0, 0, 1, 32'h11, 0);
    check("fill1", 32'(count3), 1);
    step(0, 0, 1, 32'h22, 0);
    check("fill2", 32'(count3), 2);
    step(0, 0, 1, 32'h33, 0);
    check("fill3", 32'(count3), 3);
    check("full_in_rdy3", 32'(in_rdy3), 0);
    step(0, 0, 1, 32'h44, 0);
    check("refused_count3", 32'(count3), 3);
    check("head11", out3, 32'h11);
    step(0, 0, 0, 0, 1);
    check("head22", out3, 32'h22);
    step(0, 0, 0, 0, 1);
    check("head33", out3, 32'h33);
    step(0, 0, 0, 0, 1);
    check("drained_out_val3", 32'(out_val3), 0);
    step(0, 0, 0, 0, 1);

    // simultaneous push/pop at count=1 with pointer wrap
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 1);
    check("pp_count3", 32'(count3), 1);
    check("pp_outB", out3, 32'hB);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h100 + i, 1);
    check("pp_wrap_out3", out3, 32'h109);

    // full with pop on SIZE=2
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h1, 0);
    step(0, 0, 1, 32'h2, 0);
    check("full2_in_rdy", 32'(in_rdy2), 0);
    step(0, 0, 1, 32'h3, 1);
    check("fullpop_count2", 32'(count2), 1);
    check("fullpop_out2", out2, 32'h2);
    step(0, 0, 1, 32'h3, 0);
    check("retry_count2", 32'(count2), 2);

    // flush with concurrent push and pop
    step(0, 1, 1, 32'h55, 1);
    check("flush_count3", 32'(count3), 0);
    check("flush_out_val3", 32'(out_val3), 0);
    step(0, 0, 0, 0, 1);

    // reset mid-stream
    step(0, 0, 1, 32'h61, 0);
    step(0, 0, 1, 32'h62, 0);
    step(1, 0, 1, 32'h63, 0);
    check("midrst_count3", 32'(count3), 0);
    step(0, 0, 1, 32'h77, 0);
    check("push77_out3", out3, 32'h77);
    check("push77_val3", 32'(out_val3), 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 31) == 0),
           $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    end

    rst = 0; init = 0; in_val = 0; out_rdy = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
